// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass).
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    // Widest init value the helper can produce before truncation.
    localparam int INIT_VAL_W = 64;

    // Init value of entry idx: the index itself (masked to data_w) or zero.
    function automatic logic [INIT_VAL_W-1:0] init_value(
        input logic [31:0] idx,
        input int          init_index,
        input int          data_w
    );
        logic [INIT_VAL_W-1:0] mask;
        if (data_w >= INIT_VAL_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << data_w) - 64'd1;
        end
        if (init_index != 0) begin
            return {32'd0, idx} & mask;
        end
        return '0;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset initialisation sequencer: FSM, entry counter and ready flag.
// Optional feature macro: REGFILE_BYPASS_EN (not used in this file).
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr,
    output logic [DATA_W-1:0] o_init_data,
    output logic              o_ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [31:0]       w_idx;
    logic [INIT_VAL_W-1:0] w_init_val;

    // State and counter registers; reset restarts the sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: walk every entry once, leave INIT on the last one
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            INIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_idx      = 32'(r_cnt[ADDR_W-1:0]);
    assign w_init_val = init_value(w_idx, INIT_INDEX, DATA_W);

    // Outputs: init write port is live only in INIT and never under reset
    always_comb begin
        o_init_we   = (r_state == INIT) && !rst;
        o_init_addr = r_cnt[ADDR_W-1:0];
        o_init_data = DATA_W'(w_init_val);
        o_ready     = (r_state == RUN);
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with hardware init sequencer.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass in RUN).
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0] busW,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_data;
    logic              w_ready;
    logic              w_ext_we;

    regfile_init_seq #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .INIT_INDEX (INIT_INDEX)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr),
        .o_init_data (w_init_data),
        .o_ready     (w_ready)
    );

    // External writes only in RUN, never to entry 0, never under reset
    assign w_ext_we = w_ready && wr && (Rw != '0) && !rst;
    assign ready    = w_ready;

    // Storage: init port while sequencing, external port afterwards
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= w_init_data;
        end else if (w_ext_we) begin
            r_mem[Rw] <= busW;
        end
    end

    // Read port A: zero until ready and for entry 0
    always_comb begin
        busA = '0;
        if (w_ready && (Ra != '0)) begin
            busA = r_mem[Ra];
`ifdef REGFILE_BYPASS_EN
            if (w_ext_we && (Rw == Ra)) begin
                busA = busW;
            end
`endif
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        busB = '0;
        if (w_ready && (Rb != '0)) begin
            busB = r_mem[Rb];
`ifdef REGFILE_BYPASS_EN
            if (w_ext_we && (Rw == Rb)) begin
                busB = busW;
            end
`endif
        end
    end

endmodule
